// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
//
// Round/match sequencer for the two-player fighter. It applies hit damage to
// both health bars and runs the round state machine:
//   IDLE -> INTRO (countdown) -> FIGHT -> KO (pause) -> INTRO ... -> OVER.
// All state advances only on clk edges where the frame strobe SCEN is high.
//
// Optional feature macro: MATCH_TIMER_EN
//   defined   : round_time counts down during FIGHT. A timeout ends the round
//               on hp comparison. A KO in the same frame takes priority.
//   undefined : round_time is constant 0 and rounds end only by KO.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   SCEN                : one-cycle frame strobe
//   start               : level, leaves IDLE/OVER (ignored elsewhere)
//   p1/p2_hit_event     : player was hit this frame (used only in FIGHT)
//   fight_active        : high only in FIGHT
//   pos_reset           : one-clk pulse after each entry to INTRO
//   p1/p2_hp            : health bars
//   p1/p2_rounds        : round wins (saturate at 3)
//   round_time          : frames remaining in the round
//   state               : IDLE=0, INTRO=1, FIGHT=2, KO=3, OVER=4
//   winner              : last round result, 0 none, 1 P1, 2 P2, 3 draw
//   match_over          : high in OVER
// ---------------------------------------------------------------------------
module match_controller #(
  parameter int unsigned HP_MAX        = 100,
  parameter int unsigned DMG           = 10,
  parameter int unsigned INTRO_FRAMES  = 120,
  parameter int unsigned KO_FRAMES     = 90,
  parameter int unsigned ROUND_FRAMES  = 5400,
  parameter int unsigned ROUNDS_TO_WIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCEN,
  input  logic        start,
  input  logic        p1_hit_event,
  input  logic        p2_hit_event,
  output logic        fight_active,
  output logic        pos_reset,
  output logic [6:0]  p1_hp,
  output logic [6:0]  p2_hp,
  output logic [1:0]  p1_rounds,
  output logic [1:0]  p2_rounds,
  output logic [12:0] round_time,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic        match_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTRO = 3'd1,
    S_FIGHT = 3'd2,
    S_KO    = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_P1   = 2'd1,
    W_P2   = 2'd2,
    W_DRAW = 2'd3
  } result_t;

`ifdef MATCH_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [6:0]  HP_INIT    = 7'(HP_MAX);
  localparam logic [6:0]  DMG_AMT    = 7'(DMG);
  localparam logic [15:0] INTRO_LAST = 16'(INTRO_FRAMES - 1);
  localparam logic [15:0] KO_LAST    = 16'(KO_FRAMES - 1);
  localparam logic [1:0]  WIN_ROUNDS = 2'(ROUNDS_TO_WIN);
  localparam logic [12:0] ROUND_INIT = TIMER_EN ? 13'(ROUND_FRAMES) : 13'd0;

  state_t      state_q,     state_d;
  result_t     winner_q,    winner_d;
  logic [6:0]  p1_hp_q,     p1_hp_d;
  logic [6:0]  p2_hp_q,     p2_hp_d;
  logic [1:0]  p1_rounds_q, p1_rounds_d;
  logic [1:0]  p2_rounds_q, p2_rounds_d;
  logic [12:0] round_time_q, round_time_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        pos_reset_q, pos_reset_d;

  logic        enter_intro;
  logic        round_end;
  logic        timeout;
  result_t     result;

  function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic hit);
    if (!hit) return hp;
    return (hp > DMG_AMT) ? hp - DMG_AMT : 7'd0;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] r);
    return (r == 2'd3) ? r : r + 2'd1;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      winner_q     <= W_NONE;
      p1_hp_q      <= HP_INIT;
      p2_hp_q      <= HP_INIT;
      p1_rounds_q  <= 2'd0;
      p2_rounds_q  <= 2'd0;
      round_time_q <= ROUND_INIT;
      frame_cnt_q  <= 16'd0;
      pos_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      p1_hp_q      <= p1_hp_d;
      p2_hp_q      <= p2_hp_d;
      p1_rounds_q  <= p1_rounds_d;
      p2_rounds_q  <= p2_rounds_d;
      round_time_q <= round_time_d;
      frame_cnt_q  <= frame_cnt_d;
      pos_reset_q  <= pos_reset_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    winner_d     = winner_q;
    p1_hp_d      = p1_hp_q;
    p2_hp_d      = p2_hp_q;
    p1_rounds_d  = p1_rounds_q;
    p2_rounds_d  = p2_rounds_q;
    round_time_d = round_time_q;
    frame_cnt_d  = frame_cnt_q;
    pos_reset_d  = 1'b0;          // self-clears on the very next clk
    enter_intro  = 1'b0;
    round_end    = 1'b0;
    timeout      = 1'b0;
    result       = W_NONE;

    if (SCEN) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            p1_rounds_d = 2'd0;
            p2_rounds_d = 2'd0;
            winner_d    = W_NONE;
            enter_intro = 1'b1;
          end
        end

        S_INTRO: begin
          if (frame_cnt_q == INTRO_LAST) begin
            state_d     = S_FIGHT;
            frame_cnt_d = 16'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end

        S_FIGHT: begin
          p1_hp_d = sat_sub(p1_hp_q, p1_hit_event);
          p2_hp_d = sat_sub(p2_hp_q, p2_hit_event);
`ifdef MATCH_TIMER_EN
          round_time_d = (round_time_q == 13'd0) ? 13'd0 : round_time_q - 13'd1;
          timeout      = (round_time_d == 13'd0);
`endif
          // KO is judged on the post-damage values and beats a timeout.
          if (p1_hp_d == 7'd0 || p2_hp_d == 7'd0) begin
            round_end = 1'b1;
            if (p1_hp_d == 7'd0 && p2_hp_d == 7'd0) result = W_DRAW;
            else if (p1_hp_d == 7'd0)               result = W_P2;
            else                                    result = W_P1;
          end else if (timeout) begin
            round_end = 1'b1;
            if (p1_hp_d > p2_hp_d)      result = W_P1;
            else if (p1_hp_d < p2_hp_d) result = W_P2;
            else                        result = W_DRAW;
          end
          if (round_end) begin
            winner_d    = result;
            if (result == W_P1) p1_rounds_d = sat_inc(p1_rounds_q);
            if (result == W_P2) p2_rounds_d = sat_inc(p2_rounds_q);
            state_d     = S_KO;
            frame_cnt_d = 16'd0;
          end
        end

        S_KO: begin
          if (frame_cnt_q == KO_LAST) begin
            frame_cnt_d = 16'd0;
            if (p1_rounds_q == WIN_ROUNDS || p2_rounds_q == WIN_ROUNDS)
              state_d = S_OVER;
            else
              enter_intro = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end

        S_OVER: begin
          // A new match keeps the last round result visible in winner.
          if (start) begin
            p1_rounds_d = 2'd0;
            p2_rounds_d = 2'd0;
            enter_intro = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase

      if (enter_intro) begin
        state_d      = S_INTRO;
        p1_hp_d      = HP_INIT;
        p2_hp_d      = HP_INIT;
        round_time_d = ROUND_INIT;
        frame_cnt_d  = 16'd0;
        pos_reset_d  = 1'b1;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    state        = state_q;
    fight_active = (state_q == S_FIGHT);
    match_over   = (state_q == S_OVER);
    pos_reset    = pos_reset_q;
    p1_hp        = p1_hp_q;
    p2_hp        = p2_hp_q;
    p1_rounds    = p1_rounds_q;
    p2_rounds    = p2_rounds_q;
    round_time   = round_time_q;
    winner       = winner_q;
  end

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
//
// Bench for match_controller with HP_MAX=30, DMG=10, INTRO_FRAMES=3,
// KO_FRAMES=2, ROUND_FRAMES=10 and SCEN every 4 clk. Expected output
// snapshots are queued as each frame is driven and compared once the frame
// edge has passed. Define MATCH_TIMER_EN for both DUT and bench to exercise
// the round timer.
// ---------------------------------------------------------------------------
module tb_match_controller;

`ifdef MATCH_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        SCEN;
  logic        start;
  logic        p1_hit_event;
  logic        p2_hit_event;
  logic        fight_active;
  logic        pos_reset;
  logic [6:0]  p1_hp;
  logic [6:0]  p2_hp;
  logic [1:0]  p1_rounds;
  logic [1:0]  p2_rounds;
  logic [12:0] round_time;
  logic [2:0]  state;
  logic [1:0]  winner;
  logic        match_over;

  match_controller #(
    .HP_MAX(30), .DMG(10), .INTRO_FRAMES(3), .KO_FRAMES(2),
    .ROUND_FRAMES(10), .ROUNDS_TO_WIN(2)
  ) dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .start(start),
    .p1_hit_event(p1_hit_event), .p2_hit_event(p2_hit_event),
    .fight_active(fight_active), .pos_reset(pos_reset),
    .p1_hp(p1_hp), .p2_hp(p2_hp), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .round_time(round_time), .state(state), .winner(winner), .match_over(match_over)
  );

  always #5 clk = ~clk;

  // pr0: pos_reset just after the frame edge, pr1: one clk later
  typedef struct packed {
    logic [2:0] st;
    logic       fa;
    logic       mo;
    logic [6:0] h1;
    logic [6:0] h2;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] w;
    logic       pr0;
    logic       pr1;
  } snap_t;

  snap_t sb[$];
  snap_t obs;
  snap_t exp_s;
  int    checks = 0;
  int    errors = 0;

  function automatic snap_t mk(input int st, input int h1, input int h2,
                               input int r1, input int r2, input int w, input bit pr);
    snap_t s;
    s.st  = 3'(st);
    s.fa  = (st == 2);
    s.mo  = (st == 4);
    s.h1  = 7'(h1);
    s.h2  = 7'(h2);
    s.r1  = 2'(r1);
    s.r2  = 2'(r2);
    s.w   = 2'(w);
    s.pr0 = pr;
    s.pr1 = 1'b0;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d fa=%0d mo=%0d hp=%0d/%0d rnd=%0d/%0d w=%0d pr=%0d%0d",
                     s.st, s.fa, s.mo, s.h1, s.h2, s.r1, s.r2, s.w, s.pr0, s.pr1);
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.st  = state;
    s.fa  = fight_active;
    s.mo  = match_over;
    s.h1  = p1_hp;
    s.h2  = p2_hp;
    s.r1  = p1_rounds;
    s.r2  = p2_rounds;
    s.w   = winner;
    s.pr0 = pos_reset;
    s.pr1 = 1'b0;
    return s;
  endfunction

  // One frame: 4 clk with SCEN on the first edge. stim = {start, p1_hit, p2_hit}.
  task automatic frame(input logic [2:0] stim, input snap_t e);
    sb.push_back(e);
    @(negedge clk);
    SCEN = 1'b1;
    {start, p1_hit_event, p2_hit_event} = stim;
    @(posedge clk); #1;
    obs = sample();
    SCEN = 1'b0;
    start = 1'b0; p1_hit_event = 1'b0; p2_hit_event = 1'b0;
    @(posedge clk); #1;
    obs.pr1 = pos_reset;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; SCEN = 1'b0; start = 1'b0;
    p1_hit_event = 1'b0; p2_hit_event = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = sample();
    exp_s = mk(0, 30, 30, 0, 0, 0, 1'b0);
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL reset_state: got %s want %s", fmt(obs), fmt(exp_s));
    end
    checks++;
    if (round_time !== 13'(TMR ? 10 : 0)) begin
      errors++;
      $display("FAIL reset_round_time: got %0d want %0d", round_time, TMR ? 10 : 0);
    end
    @(negedge clk);
    reset = 1'b0;
    // start must be seen only on a SCEN edge
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL start_without_scen: got state %0d want 0", state);
    end
    start = 1'b0;
  endtask

  task automatic test_start_intro();
    logic [2:0] stim [4] = '{3'b100, 3'b011, 3'b011, 3'b000};
    snap_t e [4];
    e = '{mk(1, 30, 30, 0, 0, 0, 1'b1), mk(1, 30, 30, 0, 0, 0, 1'b0),
          mk(1, 30, 30, 0, 0, 0, 1'b0), mk(2, 30, 30, 0, 0, 0, 1'b0)};
    for (int i = 0; i < 4; i++) begin
      frame(stim[i], e[i]);
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL start_intro[%0d]: got %s want %s", i, fmt(obs), fmt(exp_s));
      end
    end
    checks++;
    if (round_time !== 13'(TMR ? 10 : 0)) begin
      errors++;
      $display("FAIL fight_entry_round_time: got %0d want %0d", round_time, TMR ? 10 : 0);
    end
  endtask

  task automatic test_p2_hits();
    logic [2:0] stim [5] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    snap_t e [5];
    e = '{mk(2, 30, 20, 0, 0, 0, 1'b0), mk(2, 30, 10, 0, 0, 0, 1'b0),
          mk(3, 30, 0, 1, 0, 1, 1'b0),  mk(3, 30, 0, 1, 0, 1, 1'b0),
          mk(1, 30, 30, 1, 0, 1, 1'b1)};
    for (int i = 0; i < 5; i++) begin
      frame(stim[i], e[i]);
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL p2_hits[%0d]: got %s want %s", i, fmt(obs), fmt(exp_s));
      end
    end
    checks++;
    if (round_time !== 13'(TMR ? 10 : 0)) begin
      errors++;
      $display("FAIL intro_reload_round_time: got %0d want %0d", round_time, TMR ? 10 : 0);
    end
  endtask

  task automatic test_double_hit_draw();
    logic [2:0] stim [8] = '{3'b000, 3'b000, 3'b000, 3'b011,
                             3'b011, 3'b011, 3'b000, 3'b000};
    snap_t e [8];
    e = '{mk(1, 30, 30, 1, 0, 1, 1'b0), mk(1, 30, 30, 1, 0, 1, 1'b0),
          mk(2, 30, 30, 1, 0, 1, 1'b0), mk(2, 20, 20, 1, 0, 1, 1'b0),
          mk(2, 10, 10, 1, 0, 1, 1'b0), mk(3, 0, 0, 1, 0, 3, 1'b0),
          mk(3, 0, 0, 1, 0, 3, 1'b0),   mk(1, 30, 30, 1, 0, 3, 1'b1)};
    for (int i = 0; i < 8; i++) begin
      frame(stim[i], e[i]);
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL draw[%0d]: got %s want %s", i, fmt(obs), fmt(exp_s));
      end
    end
  endtask

  task automatic test_match_over();
    logic [2:0] stim [14] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000,
                              3'b000, 3'b011, 3'b011, 3'b100, 3'b100, 3'b000, 3'b000};
    snap_t e [14];
    e = '{mk(1, 30, 30, 1, 0, 3, 1'b0), mk(1, 30, 30, 1, 0, 3, 1'b0),
          mk(2, 30, 30, 1, 0, 3, 1'b0), mk(2, 30, 20, 1, 0, 3, 1'b0),
          mk(2, 30, 10, 1, 0, 3, 1'b0), mk(3, 30, 0, 2, 0, 1, 1'b0),
          mk(3, 30, 0, 2, 0, 1, 1'b0),  mk(4, 30, 0, 2, 0, 1, 1'b0),
          mk(4, 30, 0, 2, 0, 1, 1'b0),  mk(4, 30, 0, 2, 0, 1, 1'b0),
          mk(1, 30, 30, 0, 0, 1, 1'b1), mk(1, 30, 30, 0, 0, 1, 1'b0),
          mk(1, 30, 30, 0, 0, 1, 1'b0), mk(2, 30, 30, 0, 0, 1, 1'b0)};
    for (int i = 0; i < 14; i++) begin
      frame(stim[i], e[i]);
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL match_over[%0d]: got %s want %s", i, fmt(obs), fmt(exp_s));
      end
    end
  endtask

  task automatic test_reset_mid_fight();
    logic [2:0] stim [2] = '{3'b010, 3'b010};
    snap_t e [2];
    e = '{mk(2, 20, 30, 0, 0, 1, 1'b0), mk(2, 10, 30, 0, 0, 1, 1'b0)};
    for (int i = 0; i < 2; i++) begin
      frame(stim[i], e[i]);
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL pre_reset[%0d]: got %s want %s", i, fmt(obs), fmt(exp_s));
      end
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    obs = sample();
    exp_s = mk(0, 30, 30, 0, 0, 0, 1'b0);
    checks++;
    if (obs !== exp_s) begin
      errors++;
      $display("FAIL reset_mid_fight: got %s want %s", fmt(obs), fmt(exp_s));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    snap_t e;
    int    rt_exp;
    for (int i = 0; i < 14; i++) begin
      if (i == 0)      e = mk(1, 30, 30, 0, 0, 0, 1'b1);
      else if (i < 3)  e = mk(1, 30, 30, 0, 0, 0, 1'b0);
      else if (i == 3) e = mk(2, 30, 30, 0, 0, 0, 1'b0);
      else if (i < 13) e = mk(2, 20, 30, 0, 0, 0, 1'b0);
      else if (TMR)    e = mk(3, 20, 30, 0, 1, 2, 1'b0);
      else             e = mk(2, 20, 30, 0, 0, 0, 1'b0);
      frame((i == 0) ? 3'b100 : (i == 4) ? 3'b010 : 3'b000, e);
      exp_s = sb.pop_front();
      checks++;
      if (obs !== exp_s) begin
        errors++;
        $display("FAIL timeout[%0d]: got %s want %s", i, fmt(obs), fmt(exp_s));
      end
      if (i >= 4) begin
        rt_exp = TMR ? 10 - (i - 3) : 0;
        checks++;
        if (round_time !== 13'(rt_exp)) begin
          errors++;
          $display("FAIL round_time[%0d]: got %0d want %0d", i, round_time, rt_exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_intro();
    test_p2_hits();
    test_double_hit_draw();
    test_match_over();
    test_reset_mid_fight();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Round/match sequencer for the two-player fighter. Consumes the per-player hit pulses from the hit resolver, applies damage to both health bars, and runs the round state machine (intro countdown, fight, KO pause, match over). Its `fight_active` output gates attack damage and player input. Its `pos_reset` pulse re-spawns both players at the start of every round. All sequencing advances on the frame strobe `SCEN`.

## Interface
Parameters:
- `HP_MAX`, 100: starting health per player, 7-bit.
- `DMG`, 10: health removed per hit event.
- `INTRO_FRAMES`, 120: frames spent in INTRO before FIGHT.
- `KO_FRAMES`, 90: frames spent in KO before the next round or OVER.
- `ROUND_FRAMES`, 5400: round time limit in frames, 13-bit.
- `ROUNDS_TO_WIN`, 2: round wins needed to take the match.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `SCEN`, in, 1: one-cycle frame strobe. All state changes occur only on `clk` edges where `SCEN`=1.
- `start`, in, 1: level, sampled on `SCEN` cycles. Leaves IDLE/OVER.
- `p1_hit_event`, in, 1: P1 was hit this frame.
- `p2_hit_event`, in, 1: P2 was hit this frame.
- `fight_active`, out, 1: high only in FIGHT.
- `pos_reset`, out, 1: one-`clk` pulse on entry to INTRO.
- `p1_hp`, out, 7: P1 health.
- `p2_hp`, out, 7: P2 health.
- `p1_rounds`, out, 2: P1 round wins.
- `p2_rounds`, out, 2: P2 round wins.
- `round_time`, out, 13: frames remaining in the round.
- `state`, out, 3: IDLE=0, INTRO=1, FIGHT=2, KO=3, OVER=4.
- `winner`, out, 2: 0 none, 1 P1, 2 P2, 3 draw. Holds the last round's result.
- `match_over`, out, 1: high in OVER.

## Operation
- **Reset values:**
  - `state`=IDLE.
  - `p1_hp`=`p2_hp`=`HP_MAX`.
  - Round counters 0.
  - `round_time`=`ROUND_FRAMES` (0 if timer compiled out).
  - `winner`=0.
  - `fight_active`=`pos_reset`=`match_over`=0.
  - Internal frame counter 0.
- **IDLE:** `start` -> INTRO. Clears round counters and `winner`.
- **INTRO entry:**
  - hp reloaded to `HP_MAX`.
  - `round_time` reloaded.
  - Frame counter cleared.
  - `pos_reset` pulsed.
- **INTRO:** counts `INTRO_FRAMES` `SCEN` cycles, then -> FIGHT.
- **FIGHT:**
  - Each `SCEN` cycle: if `p1_hit_event`, `p1_hp` -= `DMG`; if `p2_hit_event`, `p2_hp` -= `DMG`.
  - Subtraction saturates at 0.
  - Both events in one frame apply both decrements.
  - Hit events outside FIGHT are ignored.
- **KO detection (on post-update values):**
  - Only `p1_hp`=0: P2 wins round.
  - Only `p2_hp`=0: P1 wins round.
  - Both 0: draw.
  - Result goes to `winner`. Winner's counter increments; a draw credits nobody. Next state -> KO.
- **KO:** counts `KO_FRAMES` `SCEN` cycles. Then either counter = `ROUNDS_TO_WIN` -> OVER; else -> INTRO.
- **OVER:**
  - hp, rounds and `winner` frozen.
  - `start` -> INTRO with round counters cleared (new match).
- `start` is ignored in INTRO/FIGHT/KO.
- Round counters saturate at 3.

## Timing
- Registered outputs. `state` and its decoded outputs update on the `SCEN` edge that makes the transition.
- Hit-to-hp latency is one `clk` (the same `SCEN` edge).
- KO is entered on the same edge as the fatal hp update.
- `INTRO_FRAMES`=N means exactly N `SCEN` edges in INTRO. The Nth edge leaves. The same rule applies to `KO_FRAMES`.
- `pos_reset` is high for exactly the one `clk` cycle following the edge that enters INTRO. It never spans two cycles, regardless of `SCEN` spacing.
- Non-`SCEN` cycles: all state held; `pos_reset` still self-clears.
- `reset` mid-round: returns immediately to reset values and discards all state.

## Configuration
- `MATCH_TIMER_EN` defined:
  - `round_time` decrements each FIGHT `SCEN` cycle.
  - On reaching 0 with no KO that frame: higher hp wins the round; equal hp is a draw. Next state -> KO.
  - A KO in the same frame takes priority.
- `MATCH_TIMER_EN` undefined: `round_time` is constant 0 and rounds end only by KO.

## Test plan
Bench parameters: `HP_MAX`=30, `DMG`=10, `INTRO_FRAMES`=3, `KO_FRAMES`=2, `ROUND_FRAMES`=10, `SCEN` every 4 `clk`.

1. **Start / intro:** reset, then `start` on one `SCEN`.
   - `state`=1 and `pos_reset` high for one `clk`.
   - FIGHT (`fight_active`=1) after exactly 3 more `SCEN` edges.
2. **Three P2 hits:** P2 hits on 3 frames.
   - `p2_hp` goes 20, 10, 0.
   - `state`=3, `winner`=1, `p1_rounds`=1.
   - After 2 `SCEN`, `state`=1 and hp=30/30.
3. **Double hit / draw:** `p1_hp`=`p2_hp`=10, both hit events in one frame.
   - Both hp=0, `winner`=3, no round credited.
4. **Match over:** P1 wins 2 rounds.
   - `state`=4 and `match_over`=1.
   - Hit events ignored; hp frozen.
   - `start` -> INTRO with rounds 0/0.
5. **Timeout (`MATCH_TIMER_EN`):** one P1 hit (`p1_hp`=20), then idle.
   - `round_time` reaches 0 on the 10th FIGHT frame.
   - `winner`=2, `state`=3.
6. **Reset mid-FIGHT:** assert `reset` with `p1_hp`=10.
   - Same cycle: `state`=0, hp=30, `fight_active`=0.
